// File: rtl/seg7_reader.sv
// Observes a 7-segment bus, waits for each pattern to hold steady, and reports
// new stable patterns as digit/blank/illegal over valid/ready. Optional error counter: SEG7_READER_ERRCNT_EN.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] display,
  output logic [3:0] value,
  output logic       blank,
  output logic       illegal,
  output logic       valid,
  input  logic       ready,
  output logic       overrun
`ifdef SEG7_READER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [6:0] samp_q, samp_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] acc_q, acc_d;
  logic       have_q, have_d;
  logic [3:0] value_q, value_d;
  logic       blank_q, blank_d;
  logic       illegal_q, illegal_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic [7:0] err_q, err_d;

  logic [6:0] seg;
  logic       changed;
  logic       accept;
  logic       emit;
  logic [5:0] dec;

  // Glyph decode, returns {illegal, blank, value}; illegal codes force value to 0.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = {2'b00, 4'h0};
      7'h06: decode = {2'b00, 4'h1};
      7'h5B: decode = {2'b00, 4'h2};
      7'h4F: decode = {2'b00, 4'h3};
      7'h66: decode = {2'b00, 4'h4};
      7'h6D: decode = {2'b00, 4'h5};
      7'h7D: decode = {2'b00, 4'h6};
      7'h07: decode = {2'b00, 4'h7};
      7'h7F: decode = {2'b00, 4'h8};
      7'h6F: decode = {2'b00, 4'h9};
      7'h77: decode = {2'b00, 4'hA};
      7'h7C: decode = {2'b00, 4'hB};
      7'h39: decode = {2'b00, 4'hC};
      7'h5E: decode = {2'b00, 4'hD};
      7'h79: decode = {2'b00, 4'hE};
      7'h71: decode = {2'b00, 4'hF};
      7'h00: decode = {2'b01, 4'h0};
      default: decode = {2'b10, 4'h0};
    endcase
  endfunction

  assign seg     = ACTIVE_LOW ? ~display : display;
  assign changed = (seg != samp_q);
  assign dec     = decode(samp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      have_q    <= 1'b0;
      value_q   <= 4'h0;
      blank_q   <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      have_q    <= have_d;
      value_q   <= value_d;
      blank_q   <= blank_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
    samp_q <= samp_d;
    acc_q  <= acc_d;
  end

  // Settling state machine: restart the count on any change, accept after a full hold.
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        samp_d  = seg;
        cnt_d   = 8'd0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (changed) begin
          samp_d = seg;
          cnt_d  = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          state_d = LOCKED;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LOCKED: begin
        if (changed) begin
          samp_d  = seg;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) samp_d = seg;
  end

  // Result registers and handshake; a repeat of the last accepted code is suppressed.
  always_comb begin
    acc_d     = acc_q;
    have_d    = have_q;
    value_d   = value_q;
    blank_d   = blank_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    err_d     = err_q;
    emit      = accept && (!have_q || samp_q != acc_q);
    if (accept) begin
      acc_d  = samp_q;
      have_d = 1'b1;
    end
    if (emit) begin
      value_d   = dec[3:0];
      blank_d   = dec[4];
      illegal_d = dec[5];
      valid_d   = 1'b1;
      if (valid_q && !ready) overrun_d = 1'b1;
      if (dec[5] && err_q != 8'hFF) err_d = err_q + 8'd1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  assign value   = value_q;
  assign blank   = blank_q;
  assign illegal = illegal_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
`ifdef SEG7_READER_ERRCNT_EN
  assign err_count = err_q;
`else
  logic unused_err;
  assign unused_err = ^err_q;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (STABLE_CYCLES=4, ACTIVE_LOW=1).
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] display;
  logic [3:0] value;
  logic       blank;
  logic       illegal;
  logic       valid;
  logic       ready;
  logic       overrun;
`ifdef SEG7_READER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int passes = 0;
  int total  = 0;

  seg7_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .display(display), .value(value), .blank(blank),
    .illegal(illegal), .valid(valid), .ready(ready), .overrun(overrun)
`ifdef SEG7_READER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet(input int n, input string tag);
    repeat (n) begin
      tick(1);
      chk(tag, {7'd0, valid}, 8'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b1;
    display = ~7'h3F;
    tick(3);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_value", {4'd0, value}, 8'd0);
    chk("rst_blank", {7'd0, blank}, 8'd0);
    chk("rst_illegal", {7'd0, illegal}, 8'd0);
    chk("rst_overrun", {7'd0, overrun}, 8'd0);

    // Digit 0: captured at E0, reported after E0+4
    rst = 1'b0;
    tick(1);
    quiet(3, "d0_wait");
    tick(1);
    chk("d0_valid", {7'd0, valid}, 8'd1);
    chk("d0_value", {4'd0, value}, 8'd0);
    chk("d0_blank", {7'd0, blank}, 8'd0);
    chk("d0_illegal", {7'd0, illegal}, 8'd0);

    // 06 for 3 edges only, then 5B held
    display = ~7'h06;
    quiet(3, "d1_short");
    display = ~7'h5B;
    quiet(4, "d2_wait");
    tick(1);
    chk("d2_valid", {7'd0, valid}, 8'd1);
    chk("d2_value", {4'd0, value}, 8'd2);

    // 4F long hold with a one-cycle glitch
    display = ~7'h4F;
    quiet(4, "d3_wait");
    tick(1);
    chk("d3_valid", {7'd0, valid}, 8'd1);
    chk("d3_value", {4'd0, value}, 8'd3);
    quiet(45, "d3_hold");
    display = ~7'h00;
    quiet(1, "glitch");
    display = ~7'h4F;
    quiet(10, "glitch_back");

    // Overrun with ready low
    ready = 1'b0;
    display = ~7'h66;
    quiet(4, "d4_wait");
    tick(1);
    chk("d4_valid", {7'd0, valid}, 8'd1);
    chk("d4_value", {4'd0, value}, 8'd4);
    chk("d4_overrun", {7'd0, overrun}, 8'd0);
    display = ~7'h6D;
    tick(1);
    chk("d5_held_valid", {7'd0, valid}, 8'd1);
    chk("d5_held_value", {4'd0, value}, 8'd4);
    tick(3);
    chk("d5_pre_overrun", {7'd0, overrun}, 8'd0);
    tick(1);
    chk("d5_valid", {7'd0, valid}, 8'd1);
    chk("d5_value", {4'd0, value}, 8'd5);
    chk("d5_overrun", {7'd0, overrun}, 8'd1);
    ready = 1'b1;
    tick(1);
    chk("d5_drain_valid", {7'd0, valid}, 8'd0);
    chk("d5_sticky_overrun", {7'd0, overrun}, 8'd1);

    // Blank then illegal
    display = ~7'h00;
    quiet(4, "blank_wait");
    tick(1);
    chk("blank_valid", {7'd0, valid}, 8'd1);
    chk("blank_blank", {7'd0, blank}, 8'd1);
    chk("blank_illegal", {7'd0, illegal}, 8'd0);
    chk("blank_value", {4'd0, value}, 8'd0);
    display = ~7'h01;
    quiet(4, "ill_wait");
    tick(1);
    chk("ill_valid", {7'd0, valid}, 8'd1);
    chk("ill_illegal", {7'd0, illegal}, 8'd1);
    chk("ill_blank", {7'd0, blank}, 8'd0);
    chk("ill_value", {4'd0, value}, 8'd0);
`ifdef SEG7_READER_ERRCNT_EN
    chk("err_count", err_count, 8'd1);
`endif

    // Reset mid-settle on 7F (cnt_q=2), then re-report after release
    display = ~7'h7F;
    quiet(3, "d8_pre");
    rst = 1'b1;
    tick(2);
    chk("d8_rst_valid", {7'd0, valid}, 8'd0);
    chk("d8_rst_overrun", {7'd0, overrun}, 8'd0);
    chk("d8_rst_illegal", {7'd0, illegal}, 8'd0);
    rst = 1'b0;
    quiet(4, "d8_wait");
    tick(1);
    chk("d8_valid", {7'd0, valid}, 8'd1);
    chk("d8_value", {4'd0, value}, 8'd8);
    quiet(1, "d8_drain");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Decodes the 7-segment `display` bus driven by the adder/mux display path back into a 4-bit value. It sits on the observing end of that bus: in hardware self-check it is paired with the display driver, and in benches it replaces visual inspection. The block waits for each segment pattern to hold steady for a programmable number of cycles and then decodes it. It reports each new stable pattern once, over a valid/ready handshake, as a digit, a blank, or an illegal pattern.

## Interface
- `STABLE_CYCLES`, 4: consecutive cycles a pattern must hold before acceptance; legal range 1..255.
- `ACTIVE_LOW`, 1: 1 = segment lit when its bit is 0 (board polarity); 0 = lit when 1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `display` in 7: segment bus; bit0 = a, bit1 = b, … bit6 = g.
- `value` out 4: decoded hex digit of the accepted pattern.
- `blank` out 1: accepted pattern has no segments lit.
- `illegal` out 1: accepted pattern is neither blank nor one of the 16 hex glyphs.
- `valid` out 1: `value`/`blank`/`illegal` hold a new, unconsumed result.
- `ready` in 1: consumer accepts the result.
- `overrun` out 1: sticky; an unconsumed result was overwritten.

## Operation
- Normalise polarity first: `seg = ACTIVE_LOW ? ~display : display`.
- Glyph table, active-high, as gfedcba hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - 00 = blank; any other code = illegal, with `value` forced to 0.
- Registers:
  - `samp_q` (7 b): last sampled `seg`.
  - `cnt_q` (8 b): stability count.
  - `acc_q` (7 b): last accepted pattern.
  - `have_q`: at least one pattern accepted since reset.
- State machine `IDLE` / `SETTLE` / `LOCKED`:
  - `IDLE` (after reset): on each edge `samp_q <= seg`, `cnt_q <= 0`, go to `SETTLE`.
  - `SETTLE`, `seg != samp_q`: `samp_q <= seg`, `cnt_q <= 0`, stay in `SETTLE`.
  - `SETTLE`, `seg == samp_q`, `cnt_q < STABLE_CYCLES-1`: `cnt_q++`.
  - `SETTLE`, `seg == samp_q`, `cnt_q == STABLE_CYCLES-1`: accept and go to `LOCKED`.
  - Accept emits a result only if `!have_q || samp_q != acc_q`. It then sets `acc_q <= samp_q` and `have_q <= 1`.
  - `LOCKED`, `seg != samp_q`: `samp_q <= seg`, `cnt_q <= 0`, go to `SETTLE`. While unchanged, stay in `LOCKED` with no further emission.
- Handshake:
  - Emitting loads the output registers and sets `valid`.
  - `valid && ready` at an edge clears `valid`, unless an emit occurs on the same edge; then the new result loads and `valid` stays 1.
  - Emit while `valid && !ready`: new result overwrites the old one and `overrun <= 1`.
  - `overrun` clears only on `rst`.
- Patterns that settle back to the previously accepted code are not re-reported; a glitch does not duplicate a result.

## Timing
- Reset values: `value` = 0, `blank` = 0, `illegal` = 0, `valid` = 0, `overrun` = 0, state `IDLE`, `cnt_q` = 0, `have_q` = 0.
- Latency: let E0 be the edge where `samp_q` first captures a new pattern. If `seg` holds, `valid` is high after edge E0+`STABLE_CYCLES`.
- Any change before acceptance restarts the count from the edge of the change; there is no partial credit.
- With `STABLE_CYCLES` = 1, acceptance happens on the edge after capture.
- `rst` asserted mid-settle or with `valid` pending discards everything. After release, the current pattern is reported again, because `have_q` is 0.
- All outputs are registered; there is no combinational path from `display` or `ready` to any output.

## Configuration
- `SEG7_READER_ERRCNT_EN` defined:
  - Adds output `err_count` out 8: counts illegal results emitted.
  - Saturates at 255; resets to 0.
  - Increments on the emit edge, even if that emit overruns.
- Macro undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, `display` = ~7'h3F (`ACTIVE_LOW` = 1), `ready` = 1: `valid` pulses one cycle after E0+4 with `value` = 0, `blank` = 0, `illegal` = 0.
- Drive ~7'h06 for 3 cycles, then ~7'h5B held: no result for 06; one result with `value` = 2, exactly 4 edges after 5B is captured.
- Hold ~7'h4F for 50 cycles, glitch one cycle to ~7'h00, return to ~7'h4F: exactly one result (`value` = 3) is reported; the glitch produces nothing.
- With `ready` = 0: settle ~7'h66 then ~7'h6D: `valid` stays 1, `value` = 5, `overrun` = 1. Raise `ready`: `valid` drops next edge; `overrun` stays 1.
- Settle ~7'h00 then ~7'h01: first result `blank` = 1; second result `illegal` = 1, `value` = 0. With `SEG7_READER_ERRCNT_EN`, `err_count` = 1.
- Assert `rst` at `cnt_q` = 2 while settling ~7'h7F; release with 7F held: `valid` = 0 through reset, then `value` = 8 after 4 post-capture edges.
